// File: rtl/booth_mul_arbiter_if.sv
// Requester-side bus of the Booth multiplier arbiter: operand requests in,
// product responses out, one valid/ready pair per requester.
interface booth_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [2*W-1:0]    resp_data;
    logic              resp_err;

    // Requesters drive operands and response acceptance.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // The arbiter accepts operands and returns products.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential signed multiplier core among NREQ requesters.
// Round-robin grant, start pulse to the core, bounded wait for the result
// (timeout reports an error), and response return to the owning requester.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mul_arbiter_if.slave bus,
    output logic               mul_start_o,
    output logic [W-1:0]       mul_a_o,
    output logic [W-1:0]       mul_b_o,
    input  logic               mul_done_i,
    input  logic [2*W-1:0]     mul_product_i,
    output logic               busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   last_grant_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic            mul_start_q;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic [NREQ-1:0] resp_valid_q;
    logic [2*W-1:0]  resp_data_q;
    logic            resp_err_q;
    logic            busy_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Round-robin pick: first pending requester after the last one served.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        sel_a     = '0;
        sel_b     = '0;
        // Scan offsets from far to near so the nearest pending requester wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant_q) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                grant_idx = cand;
            end
        end
        grant[grant_idx] = |bus.req_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == grant_idx) begin
                sel_a = bus.req_a[i*W +: W];
                sel_b = bus.req_b[i*W +: W];
            end
        end
    end

    // Offer the grant only while idle; reset forces it low as well.
    assign bus.req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;

    // Transaction sequencer: accept, start core, wait/timeout, return response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|grant) begin
                        owner_q     <= grant_idx;
                        mul_a_q     <= sel_a;
                        mul_b_q     <= sel_b;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the limit cycle still counts as valid.
                    if (mul_done_i) begin
                        resp_data_q  <= mul_product_i;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= NREQ'(1) << owner_q;
                        state_q      <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= NREQ'(1) << owner_q;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        last_grant_q <= owner_q;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign mul_start_o    = mul_start_q;
    assign mul_a_o        = mul_a_q;
    assign mul_b_o        = mul_b_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomized checks of the multiplier arbiter. The bench plays
// the requesters and the multiplier core; expected grants come from a
// round-robin model and expected products from plain signed arithmetic.
module tb_booth_mul_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic        clk;
    logic        rst_n;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        busy;

    int n_checks;
    int n_fail;
    int last_m;

    logic [15:0] a_arr [NREQ];
    logic [15:0] b_arr [NREQ];

    booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mul_start_o  (mul_start),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_done_i   (mul_done),
        .mul_product_i(mul_product),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next owner: first pending requester after the last one served.
    function automatic int model_next(input logic [3:0] mask, input int last);
        for (int o = 1; o <= NREQ; o++) begin
            if (mask[(last + o) % NREQ]) return (last + o) % NREQ;
        end
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = a_arr[i];
            bus.req_b[i*W +: W] = b_arr[i];
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/req_ready"}, bus.req_ready, 4'b0);
        check({tag, "/resp_valid"}, bus.resp_valid, 4'b0);
        check({tag, "/mul_start"}, mul_start, 1'b0);
        check({tag, "/resp_err"}, bus.resp_err, 1'b0);
        check({tag, "/busy"}, busy, 1'b0);
        check({tag, "/resp_data"}, bus.resp_data, 32'h0);
        check({tag, "/mul_a"}, mul_a, 16'h0);
        check({tag, "/mul_b"}, mul_b, 16'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        mul_done       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        last_m = NREQ - 1;
        @(negedge clk);
    endtask

    // One full transaction for requester idx. Entered between a negedge and
    // the following posedge; returns just after the response handshake.
    task automatic txn(input string tag, input int idx, input int k, input bit hang,
                       input int bp, input bit keep, input bit spur);
        logic [3:0]         oh;
        logic signed [31:0] pa;
        logic signed [31:0] pb;
        logic [31:0]        core_p;
        logic [31:0]        exp_p;
        int                 waited;
        oh     = 4'b0001 << idx;
        pa     = $signed(a_arr[idx]);
        pb     = $signed(b_arr[idx]);
        core_p = pa * pb;
        exp_p  = hang ? 32'h0 : core_p;
        waited = 0;
        #1;
        while (bus.req_ready == 4'b0 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, "/grant"}, bus.req_ready, oh);
        @(negedge clk);
        #1;
        if (!keep) bus.req_valid[idx] = 1'b0;
        check({tag, "/start"}, mul_start, 1'b1);
        check({tag, "/mul_a"}, mul_a, a_arr[idx]);
        check({tag, "/mul_b"}, mul_b, b_arr[idx]);
        check({tag, "/busy"}, busy, 1'b1);
        check({tag, "/ready_drop"}, bus.req_ready, 4'b0);
        if (spur) begin
            mul_done    = 1'b1;
            mul_product = 32'hDEAD_BEEF;
        end
        if (hang) begin
            repeat (64) @(negedge clk);
            #1;
            check({tag, "/no_early_resp"}, bus.resp_valid, 4'b0);
            @(negedge clk);
            #1;
        end else begin
            for (int j = 1; j <= k; j++) begin
                @(negedge clk);
                mul_done = 1'b0;
                if (j == 1) begin
                    #1;
                    check({tag, "/start_pulse"}, mul_start, 1'b0);
                end
            end
            #1;
            check({tag, "/no_early_resp"}, bus.resp_valid, 4'b0);
            mul_done    = 1'b1;
            mul_product = core_p;
            @(negedge clk);
            mul_done    = 1'b0;
            mul_product = $urandom;
            #1;
        end
        check({tag, "/resp_valid"}, bus.resp_valid, oh);
        check({tag, "/resp_data"}, bus.resp_data, exp_p);
        check({tag, "/resp_err"}, bus.resp_err, hang);
        for (int j = 0; j < bp; j++) begin
            bus.resp_ready = ~oh;
            @(negedge clk);
            #1;
            check({tag, "/bp_valid"}, bus.resp_valid, oh);
            check({tag, "/bp_data"}, bus.resp_data, exp_p);
            check({tag, "/bp_no_ready"}, bus.req_ready, 4'b0);
            check({tag, "/bp_busy"}, busy, 1'b1);
        end
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = '0;
        #1;
        check({tag, "/idle_busy"}, busy, 1'b0);
        check({tag, "/idle_valid"}, bus.resp_valid, 4'b0);
        last_m = idx;
    endtask

    initial begin
        int          rr_order [5];
        logic [3:0]  mask;
        int          idx;
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        mul_done       = 1'b0;
        mul_product    = '0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        drive_ops();
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        do_reset();

        // Single transaction, 7 * -3, core takes 17 cycles.
        a_arr[0] = 16'd7;
        b_arr[0] = 16'hFFFD;
        drive_ops();
        bus.req_valid = 4'b0001;
        txn("single", 0, 17, 1'b0, 0, 1'b0, 1'b0);
        check("single/const", bus.resp_data, 32'hFFFF_FFEB);

        // Round robin with every requester pending continuously.
        do_reset();
        rr_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'(i + 1);
            b_arr[i] = 16'd10;
        end
        drive_ops();
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            check("rr/model", model_next(4'b1111, last_m), rr_order[t]);
            txn("rr", rr_order[t], 3, 1'b0, 0, 1'b1, 1'b0);
        end
        bus.req_valid = '0;

        // Back-pressure on the response with another requester pending.
        mask = 4'b1001;
        a_arr[3] = 16'h1234;
        b_arr[3] = 16'h0F0F;
        drive_ops();
        bus.req_valid = mask;
        idx = model_next(mask, last_m);
        txn("bp", idx, 2, 1'b0, 5, 1'b0, 1'b0);
        bus.req_valid = '0;

        // Hung core aborts with error; result on the limit cycle is kept.
        a_arr[1] = 16'h7FFF;
        b_arr[1] = 16'h8000;
        drive_ops();
        bus.req_valid = 4'b0010;
        txn("timeout", 1, 0, 1'b1, 0, 1'b0, 1'b0);
        bus.req_valid = 4'b0010;
        txn("limit_done", 1, 64, 1'b0, 0, 1'b0, 1'b0);

        // Reset while requester 2 is waiting on the core.
        do_reset();
        a_arr[2] = 16'd1234;
        b_arr[2] = 16'hFFFB;
        drive_ops();
        bus.req_valid = 4'b0100;
        #1;
        check("rst_mid/grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        #1;
        bus.req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid/busy_before", busy, 1'b1);
        rst_n = 1'b0;
        bus.req_valid = 4'b0110;
        #1;
        check_quiet("rst_mid");
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = NREQ - 1;
        a_arr[1] = 16'd300;
        b_arr[1] = 16'd200;
        drive_ops();
        txn("rst_after", 1, 3, 1'b0, 0, 1'b0, 1'b0);
        txn("rst_next", model_next(bus.req_valid, last_m), 2, 1'b0, 0, 1'b0, 1'b0);

        // Spurious core completions in IDLE and ISSUE are ignored.
        @(negedge clk);
        mul_done    = 1'b1;
        mul_product = 32'h1234_5678;
        @(negedge clk);
        mul_done = 1'b0;
        #1;
        check("spur_idle/busy", busy, 1'b0);
        check("spur_idle/valid", bus.resp_valid, 4'b0);
        a_arr[3] = 16'h8000;
        b_arr[3] = 16'h8000;
        drive_ops();
        bus.req_valid = 4'b1000;
        txn("spur_issue", 3, 4, 1'b0, 0, 1'b0, 1'b1);
        check("spur_issue/const", bus.resp_data, 32'h4000_0000);

        // Randomized traffic against the round-robin and arithmetic model.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = 16'($urandom);
                b_arr[i] = 16'($urandom);
            end
            drive_ops();
            mask = 4'($urandom_range(1, 15));
            bus.req_valid = mask;
            idx = model_next(mask, last_m);
            txn("rand", idx, int'($urandom_range(1, 12)), 1'b0,
                int'($urandom_range(0, 2)), 1'b0, 1'b0);
            bus.req_valid = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
